uart_rx_fifo: RTL and testbench

//  - Receive-side byte buffer directly downstream of the UART receiver: captures each

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_fifo_mem.sv | 26 ++
 rtl/uart_rx_fifo.sv | 76 +++++++
 tb/tb_uart_rx_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants and types shared by the UART receiver, transmitter and receive FIFO.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are never reset; validity is tracked by the occupancy count outside.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART receiver, with a sticky
// overflow flag for bytes dropped while full.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_W = uart_pkg::DATA_W,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem_rdata;
  logic              push;
  logic              pop;
  logic              drop;

  // Handshake: the head byte transfers on a cycle where ena & out_valid & out_ready;
  // in_valid is a strobe with no back-pressure, so a byte offered while full is lost
  // unless a pop frees its slot in that same cycle.
  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = ena & out_valid & out_ready;
  assign push      = ena & in_valid & (~full | pop);
  assign drop      = ena & in_valid & full & ~pop;
  assign out_data  = out_valid ? mem_rdata : '0;

  uart_fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear wins, so no lost byte goes unreported.
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DATA_W=8, DEPTH=8).
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic          clr_overflow = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  uart_rx_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .full        (full),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Driver tasks
  task automatic push_byte(input logic [DW-1:0] b);
    in_data  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic fill_seq(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(first + DW'(i));
      push_byte(first + DW'(i));
    end
  endtask

  task automatic pop_byte();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 4'd0)  begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (full !== 1'b0)   begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
  endtask

  task automatic test_single_push();
    push_byte(8'hA5);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_out_data got=%h exp=a5", out_data); end
    checks++; if (count !== 4'd1)     begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
    pop_byte();
    checks++; if (count !== 4'd0)     begin errors++; $display("FAIL single_drained got=%0d exp=0", count); end
  endtask

  task automatic test_fill_drain();
    fill_seq(8'h01, DEPTH);
    checks++; if (full !== 1'b1)  begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count got=%0d exp=8", count); end
    for (int n = 0; n < DEPTH + 2 && exp_q.size() > 0; n++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || out_data !== e) begin
        errors++; $display("FAIL fill_drain_data got=%h/v%b exp=%h/v1", out_data, out_valid, e);
      end
      pop_byte();
    end
    checks++; if (count !== 4'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++; $display("FAIL fill_empty got=cnt%0d v%b d%h exp=cnt0 v0 d00", count, out_valid, out_data);
    end
  endtask

  task automatic test_overflow();
    fill_seq(8'h01, DEPTH);
    push_byte(8'hFF);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (count !== 4'd8)    begin errors++; $display("FAIL ovf_count got=%0d exp=8", count); end
    // Drop and clear in the same cycle: set wins.
    clr_overflow = 1'b1;
    push_byte(8'hFE);
    clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_priority got=%b exp=1", overflow); end
    // Clear is honoured with ena low.
    ena = 1'b0;
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    ena = 1'b1;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear_ena0 got=%b exp=0", overflow); end
    for (int n = 0; n < DEPTH + 2 && exp_q.size() > 0; n++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || out_data !== e) begin
        errors++; $display("FAIL ovf_drain_data got=%h/v%b exp=%h/v1", out_data, out_valid, e);
      end
      pop_byte();
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL ovf_drained got=%0d exp=0", count); end
  endtask

  task automatic test_full_push_pop();
    fill_seq(8'h01, DEPTH);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h55);
    in_data = 8'h55; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 4'd8 || full !== 1'b1) begin
      errors++; $display("FAIL fpp_count got=%0d full=%b exp=8 full=1", count, full);
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
    for (int n = 0; n < DEPTH + 2 && exp_q.size() > 0; n++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || out_data !== e) begin
        errors++; $display("FAIL fpp_drain_data got=%h/v%b exp=%h/v1", out_data, out_valid, e);
      end
      pop_byte();
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL fpp_drained got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] b;
      b = DW'(8'h30 + 7 * i);
      in_data = b; in_valid = 1'b1;
      step();
      checks++; if (out_data !== b || count !== 4'd1) begin
        errors++; $display("FAIL b2b_stream i=%0d got=%h cnt%0d exp=%h cnt1", i, out_data, count, b);
      end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    checks++; if (count !== 4'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_end got=cnt%0d ovf%b exp=cnt0 ovf0", count, overflow);
    end
  endtask

  task automatic test_empty_push_ready();
    in_data = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 4'd1 || out_data !== 8'h3C) begin
      errors++; $display("FAIL empty_pr got=cnt%0d d%h exp=cnt1 d3c", count, out_data);
    end
    pop_byte();
  endtask

  task automatic test_ena_low();
    push_byte(8'h77);
    ena = 1'b0;
    out_ready = 1'b1; in_data = 8'h88; in_valid = 1'b1;
    step(); step();
    out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 4'd1 || out_data !== 8'h77) begin
      errors++; $display("FAIL ena0_hold got=cnt%0d d%h exp=cnt1 d77", count, out_data);
    end
    ena = 1'b1;
    exp_q.delete();
    fill_seq(8'h40, DEPTH - 1);
    ena = 1'b0;
    push_byte(8'h99);
    ena = 1'b1;
    checks++; if (overflow !== 1'b0 || count !== 4'd8) begin
      errors++; $display("FAIL ena0_no_ovf got=ovf%b cnt%0d exp=ovf0 cnt8", overflow, count);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    push_byte(8'hEE);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid_ovf_pre got=%b exp=1", overflow); end
    do_reset();
    checks++; if (count !== 4'd0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_full got=cnt%0d ovf%b v%b exp=0 0 0", count, overflow, out_valid);
    end
    fill_seq(8'hB0, 3);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL mid_hold3 got=%0d exp=3", count); end
    in_data = 8'hC1; in_valid = 1'b1; out_ready = 1'b1;
    do_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    checks++; if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 8'h00) begin
      errors++; $display("FAIL mid_reset3 got=cnt%0d v%b ovf%b d%h exp=0 0 0 00", count, out_valid, overflow, out_data);
    end
    ena = 1'b0;
    push_byte(8'h12);
    push_byte(8'h34);
    ena = 1'b1;
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_ena0_push got=cnt%0d v%b exp=cnt0 v0", count, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_empty_push_ready();
    test_ena_low();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
